xbar_config_loader: RTL and testbench

Configuration loader directly upstream of the LUT-tile crossbar. Accepts the crossbar select bitstream as a stream of narrow words over a valid/ready handshake, assembles it in a shadow register, optionally range-checks every select field, and atomically commits it to the `io_mux_configs` bus that drives the crossbar. The crossbar's routing changes only on a successful commit, never mid-load.

---
 rtl/xbar_config_loader_if.sv | 38 +++
 rtl/xbar_config_loader.sv | 133 +++++++++++++
 tb/tb_xbar_config_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/xbar_config_loader_if.sv
// -----------------------------------------------------------------------------
// xbar_config_loader_if
// Bundles the load-side handshake and the committed select bus of the crossbar
// configuration loader.
//   master : upstream loader driver (start/abort/word/valid out, status in)
//   slave  : xbar_config_loader itself
// Signals:
//   io_cfg_start, io_cfg_abort    load control
//   io_cfg_word, io_cfg_valid     data word and its valid
//   io_cfg_ready                  loader accepts a word
//   io_busy, io_cfg_done          status; done is a one-cycle commit pulse
//   io_cfg_error                  sticky range-check failure
//   io_mux_configs                active crossbar select bus
// -----------------------------------------------------------------------------
interface xbar_config_loader_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CFG_W  = 175
);
    logic              io_cfg_start;
    logic              io_cfg_abort;
    logic [WORD_W-1:0] io_cfg_word;
    logic              io_cfg_valid;
    logic              io_cfg_ready;
    logic              io_busy;
    logic              io_cfg_done;
    logic              io_cfg_error;
    logic [CFG_W-1:0]  io_mux_configs;

    modport master (
        output io_cfg_start, io_cfg_abort, io_cfg_word, io_cfg_valid,
        input  io_cfg_ready, io_busy, io_cfg_done, io_cfg_error, io_mux_configs
    );

    modport slave (
        input  io_cfg_start, io_cfg_abort, io_cfg_word, io_cfg_valid,
        output io_cfg_ready, io_busy, io_cfg_done, io_cfg_error, io_mux_configs
    );
endinterface

// File: rtl/xbar_config_loader.sv
// -----------------------------------------------------------------------------
// xbar_config_loader
// Streams the crossbar select bitstream in WORD_W-bit words (first word = LSBs)
// into a shadow register, optionally range-checks every select field, then
// commits the shadow to the active select bus in one cycle. The active bus only
// ever changes on a successful commit or on reset.
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   cfg_bus  xbar_config_loader_if.slave (handshake, status, select bus)
// Build option:
//   XBAR_CFG_RANGE_CHECK_EN  when defined, any select field >= NUM_INS aborts
//                            the commit and sets io_cfg_error; otherwise the
//                            shadow is always committed and the error is 0.
// -----------------------------------------------------------------------------
module xbar_config_loader #(
    parameter int unsigned NUM_INS  = 27,
    parameter int unsigned NUM_OUTS = 35,
    parameter int unsigned SEL_W    = 5,
    parameter int unsigned WORD_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    xbar_config_loader_if.slave  cfg_bus
);
    localparam int unsigned CFG_W     = NUM_OUTS * SEL_W;
    localparam int unsigned NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int unsigned CNT_W     = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic             error_q, error_d;
    logic             ready;
    logic             accept;
    logic             range_bad;

`ifdef XBAR_CFG_RANGE_CHECK_EN
    localparam logic [SEL_W-1:0] MaxSel = SEL_W'(NUM_INS);

    always_comb begin
        range_bad = 1'b0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            if (shadow_q[i*SEL_W +: SEL_W] >= MaxSel) begin
                range_bad = 1'b1;
            end
        end
    end
`else
    assign range_bad = 1'b0;
`endif

    // Abort takes priority over a word presented in the same cycle.
    assign ready  = (state_q == StLoad) && !cfg_bus.io_cfg_abort;
    assign accept = ready && cfg_bus.io_cfg_valid;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        error_d  = error_q;
        case (state_q)
            StIdle: begin
                if (cfg_bus.io_cfg_start) begin
                    state_d  = StLoad;
                    cnt_d    = '0;
                    shadow_d = '0;
                    error_d  = 1'b0;
                end
            end
            StLoad: begin
                if (cfg_bus.io_cfg_abort) begin
                    state_d = StIdle;
                end else if (accept) begin
                    // Bits of the final word that fall past CFG_W are dropped.
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        if (cnt_q == CNT_W'(w)) begin
                            for (int b = 0; b < WORD_W; b++) begin
                                if (w * WORD_W + b < CFG_W) begin
                                    shadow_d[w*WORD_W+b] = cfg_bus.io_cfg_word[b];
                                end
                            end
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                if (range_bad) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                active_d = shadow_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    assign cfg_bus.io_cfg_ready   = ready;
    assign cfg_bus.io_busy        = (state_q != StIdle);
    // High for the whole COMMIT cycle; falls on the edge that updates the bus.
    assign cfg_bus.io_cfg_done    = (state_q == StCommit);
    assign cfg_bus.io_cfg_error   = error_q;
    assign cfg_bus.io_mux_configs = active_q;
endmodule

// File: tb/tb_xbar_config_loader.sv
// -----------------------------------------------------------------------------
// tb_xbar_config_loader
// Scoreboarded bench for xbar_config_loader: each load expected to commit
// pushes its image; a monitor pops and compares the bus the cycle after done.
// -----------------------------------------------------------------------------
module tb_xbar_config_loader;
    localparam int unsigned NUM_INS   = 27;
    localparam int unsigned NUM_OUTS  = 35;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned CFG_W     = 175;
    localparam int unsigned NUM_WORDS = 22;
    localparam int unsigned IMG_W     = NUM_WORDS * WORD_W;

    typedef logic [CFG_W-1:0] val_t;
    typedef logic [IMG_W-1:0] img_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xbar_config_loader_if #(.WORD_W(WORD_W), .CFG_W(CFG_W)) cfg_bus ();

    xbar_config_loader #(
        .NUM_INS (NUM_INS),
        .NUM_OUTS(NUM_OUTS),
        .SEL_W   (SEL_W),
        .WORD_W  (WORD_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cfg_bus(cfg_bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    val_t sb_q[$];
    val_t bus_model = '0;
    logic done_prev = 1'b0;

    task automatic check_eq(input string tag, input val_t obs, input val_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus is compared one cycle after the done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_done", val_t'(sb_q.size() != 0), val_t'(1));
                end else begin
                    check_eq("sb_bus", cfg_bus.io_mux_configs, sb_q.pop_front());
                end
            end
            done_prev = cfg_bus.io_cfg_done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic img_t make_img(input bit reverse);
        img_t img = '0;
        for (int i = 0; i < NUM_OUTS; i++) begin
            img[i*SEL_W +: SEL_W] = reverse ? SEL_W'(NUM_INS - 1 - (i % NUM_INS))
                                            : SEL_W'(i % NUM_INS);
        end
        return img;
    endfunction

    function automatic bit model_range_bad(input img_t img);
`ifdef XBAR_CFG_RANGE_CHECK_EN
        for (int i = 0; i < NUM_OUTS; i++) begin
            if (32'(img[i*SEL_W +: SEL_W]) >= NUM_INS) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic run_load(input img_t img, input logic [NUM_WORDS-1:0] gap_before,
                            input int abort_at, input int rst_at, input string tag);
        int   t;
        int   ngaps = 0;
        bit   found = 0;
        cfg_bus.io_cfg_start = 1'b1;
        t = int'(cyc);
        step();
        cfg_bus.io_cfg_start = 1'b0;
        check_eq({tag, "_ready_after_start"}, val_t'(cfg_bus.io_cfg_ready), val_t'(1));
        check_eq({tag, "_error_cleared"}, val_t'(cfg_bus.io_cfg_error), val_t'(0));
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (gap_before[w]) begin
                cfg_bus.io_cfg_valid = 1'b0;
                step();
                ngaps++;
            end
            cfg_bus.io_cfg_word  = img[w*WORD_W +: WORD_W];
            cfg_bus.io_cfg_valid = 1'b1;
            if (w == abort_at) begin
                cfg_bus.io_cfg_abort = 1'b1;
                #1;
                check_eq({tag, "_ready_abort"}, val_t'(cfg_bus.io_cfg_ready), val_t'(0));
                step();
                cfg_bus.io_cfg_abort = 1'b0;
                cfg_bus.io_cfg_valid = 1'b0;
                check_eq({tag, "_busy_abort"}, val_t'(cfg_bus.io_busy), val_t'(0));
                check_eq({tag, "_bus_abort"}, cfg_bus.io_mux_configs, bus_model);
                return;
            end
            if (w == rst_at) begin
                reset = 1'b0;
                #1;
                bus_model = '0;
                check_eq({tag, "_bus_rst"}, cfg_bus.io_mux_configs, bus_model);
                check_eq({tag, "_busy_rst"}, val_t'(cfg_bus.io_busy), val_t'(0));
                check_eq({tag, "_ready_rst"}, val_t'(cfg_bus.io_cfg_ready), val_t'(0));
                cfg_bus.io_cfg_valid = 1'b0;
                step();
                reset = 1'b1;
                step();
                check_eq({tag, "_idle_post_rst"}, val_t'(cfg_bus.io_busy), val_t'(0));
                return;
            end
            step();
        end
        cfg_bus.io_cfg_valid = 1'b0;
        check_eq({tag, "_done_in_check"}, val_t'(cfg_bus.io_cfg_done), val_t'(0));
        if (model_range_bad(img)) begin
            step();
            check_eq({tag, "_error_set"}, val_t'(cfg_bus.io_cfg_error), val_t'(1));
            check_eq({tag, "_no_done"}, val_t'(cfg_bus.io_cfg_done), val_t'(0));
            check_eq({tag, "_busy_err"}, val_t'(cfg_bus.io_busy), val_t'(0));
            step();
            check_eq({tag, "_bus_kept"}, cfg_bus.io_mux_configs, bus_model);
        end else begin
            sb_q.push_back(img[CFG_W-1:0]);
            bus_model = img[CFG_W-1:0];
            for (int i = 0; i < 8; i++) begin
                step();
                if (cfg_bus.io_cfg_done) begin
                    found = 1;
                    break;
                end
            end
            check_eq({tag, "_done_seen"}, val_t'(found), val_t'(1));
            if (found) begin
                check_eq({tag, "_latency"}, val_t'(int'(cyc) - t), val_t'(24 + ngaps));
            end
            step();
            step();
            check_eq({tag, "_error_clear"}, val_t'(cfg_bus.io_cfg_error), val_t'(0));
        end
    endtask

    initial begin
        img_t img;
        cfg_bus.io_cfg_start = 1'b0;
        cfg_bus.io_cfg_abort = 1'b0;
        cfg_bus.io_cfg_valid = 1'b0;
        cfg_bus.io_cfg_word  = '0;
        reset = 1'b0;
        step();
        step();
        check_eq("rst_ready", val_t'(cfg_bus.io_cfg_ready), val_t'(0));
        check_eq("rst_busy",  val_t'(cfg_bus.io_busy),      val_t'(0));
        check_eq("rst_done",  val_t'(cfg_bus.io_cfg_done),  val_t'(0));
        check_eq("rst_error", val_t'(cfg_bus.io_cfg_error), val_t'(0));
        check_eq("rst_bus",   cfg_bus.io_mux_configs,       val_t'(0));
        reset = 1'b1;
        step();
        step();
        check_eq("post_rst_ready", val_t'(cfg_bus.io_cfg_ready), val_t'(0));
        check_eq("post_rst_busy",  val_t'(cfg_bus.io_busy),      val_t'(0));

        run_load(make_img(0), '0, -1, -1, "ident");
        check_eq("field30", val_t'(cfg_bus.io_mux_configs[30*SEL_W +: SEL_W]), val_t'(3));

        run_load(make_img(1), '0, -1, -1, "rev");
        run_load(make_img(0), 22'(1 << 1) | 22'(1 << 11) | 22'(1 << 21), -1, -1, "gaps");

        img = make_img(0);
        img[34*SEL_W +: SEL_W] = 5'd31;
        run_load(img, '0, -1, -1, "range");
        run_load(make_img(1), '0, -1, -1, "after_range");

        run_load(make_img(0), '0, 12, -1, "abort");
        run_load(make_img(0), '0, -1, -1, "restart");

        run_load(make_img(1), '0, -1, 15, "midrst");
        img = make_img(0);
        img[IMG_W-1] = 1'b1;
        run_load(img, '0, -1, -1, "pad_bit");

        step();
        step();
        check_eq("sb_drained", val_t'(sb_q.size()), val_t'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
